bit_position_extractor: RTL

BIT_POSITION_EXTRACTOR -- requirements
Module: bit_position_extractor

---
 rtl/bit_position_extractor_pkg.sv | 16 +
 rtl/bit_position_extractor_lowest_set_bit_finder.sv | 26 ++
 rtl/bit_position_extractor.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bit_position_extractor_pkg.sv
// Shared types and sizing for the set-bit position extractor.
// Holds the default word width, index width helper and FSM states.
package bit_position_extractor_pkg;

   localparam int WIDTH_DEF = 128;

   function automatic int idx_w_of(input int width);
      return $clog2(width);
   endfunction

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

endpackage

// File: rtl/bit_position_extractor_lowest_set_bit_finder.sv
// Combinational priority encoder: position of the lowest set bit.
// pos_o is zero when no bit is set; any_o flags a non-zero vector.
module lowest_set_bit_finder
   import bit_position_extractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int IDX_W = idx_w_of(WIDTH)
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic [IDX_W-1:0] pos_o,
   output logic             any_o
);

   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      pos_o = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            pos_o = IDX_W'(i);
         end
      end
   end

   assign any_o = |vec_i;

endmodule

// File: rtl/bit_position_extractor.sv
// Accepts a word and streams its set-bit positions, lowest first,
// one beat per cycle; an all-zero word yields a single empty beat.
module bit_position_extractor
   import bit_position_extractor_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int IDX_W = idx_w_of(WIDTH)
) (
   input  logic             clk_i,
   input  logic             srst_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             data_val_i,
   output logic             data_ready_o,
   output logic [IDX_W-1:0] index_o,
   output logic             index_val_o,
   output logic             index_last_o,
   output logic             empty_o,
   input  logic             index_ready_i
);

   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] resid_q, resid_d;
   logic [IDX_W-1:0] index_q, index_d;
   logic             last_q, last_d;
   logic             empty_q, empty_d;
   logic             ready_q, ready_d;
   logic             val_q, val_d;

   logic [WIDTH-1:0] resid_nxt;
   logic [WIDTH-1:0] fin_in;
   logic [IDX_W-1:0] fin_pos;
   logic             fin_any;
   logic             fin_le1;

   // index_q is always the lowest set bit, so this drops exactly it.
   assign resid_nxt = resid_q & (resid_q - ONE);

   assign fin_in = (state_q == IDLE) ? data_i : resid_nxt;

   // At most one bit set: true for a one-hot word and for zero.
   assign fin_le1 = ((fin_in & (fin_in - ONE)) == '0);

   lowest_set_bit_finder #(
      .WIDTH (WIDTH),
      .IDX_W (IDX_W)
   ) u_finder (
      .vec_i (fin_in),
      .pos_o (fin_pos),
      .any_o (fin_any)
   );

   always_comb begin
      state_d = state_q;
      resid_d = resid_q;
      index_d = index_q;
      last_d  = last_q;
      empty_d = empty_q;
      ready_d = ready_q;
      val_d   = val_q;
      unique case (state_q)
         IDLE: begin
            if (data_val_i) begin
               state_d = SEND;
               resid_d = data_i;
               index_d = fin_pos;
               last_d  = fin_le1;
               empty_d = ~fin_any;
               ready_d = 1'b0;
               val_d   = 1'b1;
            end
         end
         SEND: begin
            if (index_ready_i) begin
               if (last_q) begin
                  state_d = IDLE;
                  resid_d = '0;
                  index_d = '0;
                  last_d  = 1'b0;
                  empty_d = 1'b0;
                  ready_d = 1'b1;
                  val_d   = 1'b0;
               end else begin
                  resid_d = resid_nxt;
                  index_d = fin_pos;
                  last_d  = fin_le1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q <= IDLE;
         resid_q <= '0;
         index_q <= '0;
         last_q  <= 1'b0;
         empty_q <= 1'b0;
         ready_q <= 1'b1;
         val_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         resid_q <= resid_d;
         index_q <= index_d;
         last_q  <= last_d;
         empty_q <= empty_d;
         ready_q <= ready_d;
         val_q   <= val_d;
      end
   end

   assign data_ready_o = ready_q;
   assign index_o      = index_q;
   assign index_val_o  = val_q;
   assign index_last_o = last_q;
   assign empty_o      = empty_q;

endmodule
